// File: rtl/smart_cargo_uc_insercao.sv
// Control unit that inserts one transport request (origin, destination) into the
// elevator queue RAM, scanning for ride-along slots and tracking queue occupancy.
module smart_cargo_uc_insercao #(
    parameter int PROF_FILA   = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_GNT = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bordaNovoDestino,
    input  logic              gnt_fila,
    input  logic              shift_fila,
    input  logic              ramSecDifZero,
    input  logic              carona_origem,
    input  logic              carona_destino,
    input  logic              andarRepetidoOrigem,
    input  logic              andarRepetidoDestino,
    output logic              req_fila,
    output logic              enableRegDestino,
    output logic              select1,
    output logic              select3,
    output logic              zeraAddrSecundario,
    output logic              contaAddrSecundario,
    output logic              enableRegCaronaOrigem,
    output logic              fit,
    output logic              enableRAM,
    output logic              guarda_origem_ram,
    output logic              pronto,
    output logic              erro_fila_cheia,
    output logic              pedido_descartado,
    output logic [ADDR_W:0]   ocupacao,
    output logic [3:0]        db_estado
);

    localparam int TW = $clog2(TIMEOUT_GNT + 1);

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        SOLICITA       = 3'd1,
        BUSCA_ORIGEM   = 3'd2,
        INSERE_ORIGEM  = 3'd3,
        BUSCA_DESTINO  = 3'd4,
        INSERE_DESTINO = 3'd5,
        FIM            = 3'd6,
        ERRO           = 3'd7
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   ocup_q, ocup_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              cabe, ultimo, dec;

    // Origin + destination need two free entries; reject before touching the RAM.
    assign cabe   = (ocup_q <= (ADDR_W+1)'(PROF_FILA - 2));
    assign ultimo = (addr_q == ADDR_W'(PROF_FILA - 1));
    assign dec    = shift_fila && (ocup_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            addr_q   <= '0;
            ocup_q   <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            ocup_q   <= ocup_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d              = estado_q;
        cnt_d                 = '0;
        req_fila              = 1'b0;
        enableRegDestino      = 1'b0;
        select1               = 1'b0;
        select3               = 1'b0;
        zeraAddrSecundario    = 1'b0;
        contaAddrSecundario   = 1'b0;
        enableRegCaronaOrigem = 1'b0;
        fit                   = 1'b0;
        enableRAM             = 1'b0;
        guarda_origem_ram     = 1'b0;
        pronto                = 1'b0;
        erro_fila_cheia       = 1'b0;
        pedido_descartado     = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (bordaNovoDestino) begin
                    enableRegDestino = 1'b1;
                    estado_d         = SOLICITA;
                end
            end
            SOLICITA: begin
                req_fila = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (gnt_fila) begin
                    if (cabe) begin
                        zeraAddrSecundario = 1'b1;
                        estado_d           = BUSCA_ORIGEM;
                    end else begin
                        estado_d = ERRO;
                    end
                end else if (cnt_q == TW'(TIMEOUT_GNT - 1)) begin
                    estado_d = ERRO;
                end
            end
            BUSCA_ORIGEM: begin
                req_fila = 1'b1;
                select1  = 1'b1;
                select3  = (addr_q == '0);
                if (andarRepetidoOrigem) begin
                    enableRegCaronaOrigem = 1'b1;
                    contaAddrSecundario   = 1'b1;
                    estado_d              = BUSCA_DESTINO;
                end else if (carona_origem || !ramSecDifZero) begin
                    estado_d = INSERE_ORIGEM;
                end else if (ultimo) begin
                    estado_d = ERRO;
                end else begin
                    contaAddrSecundario = 1'b1;
                end
            end
            INSERE_ORIGEM: begin
                req_fila              = 1'b1;
                fit                   = 1'b1;
                enableRAM             = 1'b1;
                guarda_origem_ram     = 1'b1;
                enableRegCaronaOrigem = 1'b1;
                contaAddrSecundario   = 1'b1;
                estado_d              = BUSCA_DESTINO;
            end
            BUSCA_DESTINO: begin
                req_fila = 1'b1;
                select3  = (addr_q == '0);
                if (andarRepetidoDestino) begin
                    estado_d = FIM;
                end else if (carona_destino || !ramSecDifZero) begin
                    estado_d = INSERE_DESTINO;
                end else if (ultimo) begin
                    estado_d = ERRO;
                end else begin
                    contaAddrSecundario = 1'b1;
                end
            end
            INSERE_DESTINO: begin
                req_fila  = 1'b1;
                fit       = 1'b1;
                enableRAM = 1'b1;
                estado_d  = FIM;
            end
            FIM: begin
                pronto   = 1'b1;
                estado_d = OCIOSO;
            end
            ERRO: begin
                erro_fila_cheia = 1'b1;
                estado_d        = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        pedido_descartado = bordaNovoDestino && (estado_q != OCIOSO);

        // Reset wins over everything: no strobe may reach the datapath that cycle.
        if (reset) begin
            req_fila              = 1'b0;
            enableRegDestino      = 1'b0;
            select1               = 1'b0;
            select3               = 1'b0;
            zeraAddrSecundario    = 1'b0;
            contaAddrSecundario   = 1'b0;
            enableRegCaronaOrigem = 1'b0;
            fit                   = 1'b0;
            enableRAM             = 1'b0;
            guarda_origem_ram     = 1'b0;
            pronto                = 1'b0;
            erro_fila_cheia       = 1'b0;
            pedido_descartado     = 1'b0;
        end

        addr_d = addr_q;
        if (zeraAddrSecundario)       addr_d = '0;
        else if (contaAddrSecundario) addr_d = addr_q + 1'b1;

        // Insert and pop in the same cycle cancel out.
        ocup_d = ocup_q;
        if (enableRAM && !dec) begin
            if (ocup_q != (ADDR_W+1)'(PROF_FILA)) ocup_d = ocup_q + 1'b1;
        end else if (!enableRAM && dec) begin
            ocup_d = ocup_q - 1'b1;
        end
    end

    assign ocupacao  = ocup_q;
    assign db_estado = {1'b0, estado_q};

endmodule

// File: tb/tb_smart_cargo_uc_insercao.sv
// Table-driven bench for smart_cargo_uc_insercao: per-cycle input/expected-output
// vectors plus hand sequences for reset behaviour.
module tb_smart_cargo_uc_insercao;

    localparam int PF = 16;
    localparam int AW = 4;
    localparam int TO = 8;

    localparam logic [7:0] I_BORDA = 8'h80, I_GNT = 8'h40, I_SHIFT = 8'h20, I_RSZ = 8'h10,
                           I_CO    = 8'h08, I_CD  = 8'h04, I_RO    = 8'h02, I_RD  = 8'h01;

    localparam logic [12:0] O_REQ   = 13'h1000, O_ERD  = 13'h0800, O_SEL1   = 13'h0400,
                            O_SEL3  = 13'h0200, O_ZERA = 13'h0100, O_CONTA  = 13'h0080,
                            O_ERC   = 13'h0040, O_FIT  = 13'h0020, O_ERAM   = 13'h0010,
                            O_GUARDA= 13'h0008, O_PRONTO=13'h0004, O_ERRO   = 13'h0002,
                            O_DESC  = 13'h0001;
    localparam logic [12:0] O_INSO = O_REQ | O_FIT | O_ERAM | O_GUARDA | O_ERC | O_CONTA;
    localparam logic [12:0] O_INSD = O_REQ | O_FIT | O_ERAM;

    logic clock = 1'b0;
    logic reset;
    logic bordaNovoDestino, gnt_fila, shift_fila, ramSecDifZero;
    logic carona_origem, carona_destino, andarRepetidoOrigem, andarRepetidoDestino;
    logic req_fila, enableRegDestino, select1, select3, zeraAddrSecundario;
    logic contaAddrSecundario, enableRegCaronaOrigem, fit, enableRAM, guarda_origem_ram;
    logic pronto, erro_fila_cheia, pedido_descartado;
    logic [AW:0] ocupacao;
    logic [3:0]  db_estado;
    logic [12:0] dut_o;

    smart_cargo_uc_insercao #(.PROF_FILA(PF), .ADDR_W(AW), .TIMEOUT_GNT(TO)) dut (
        .clock(clock), .reset(reset),
        .bordaNovoDestino(bordaNovoDestino), .gnt_fila(gnt_fila), .shift_fila(shift_fila),
        .ramSecDifZero(ramSecDifZero), .carona_origem(carona_origem),
        .carona_destino(carona_destino), .andarRepetidoOrigem(andarRepetidoOrigem),
        .andarRepetidoDestino(andarRepetidoDestino),
        .req_fila(req_fila), .enableRegDestino(enableRegDestino), .select1(select1),
        .select3(select3), .zeraAddrSecundario(zeraAddrSecundario),
        .contaAddrSecundario(contaAddrSecundario), .enableRegCaronaOrigem(enableRegCaronaOrigem),
        .fit(fit), .enableRAM(enableRAM), .guarda_origem_ram(guarda_origem_ram),
        .pronto(pronto), .erro_fila_cheia(erro_fila_cheia),
        .pedido_descartado(pedido_descartado), .ocupacao(ocupacao), .db_estado(db_estado)
    );

    assign dut_o = {req_fila, enableRegDestino, select1, select3, zeraAddrSecundario,
                    contaAddrSecundario, enableRegCaronaOrigem, fit, enableRAM,
                    guarda_origem_ram, pronto, erro_fila_cheia, pedido_descartado};

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  in;
        int          st;
        logic [12:0] o;
        int          oc;
    } vec_t;

    vec_t tbl[300];
    int   n     = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [7:0] in, input int st, input logic [12:0] o, input int oc);
        tbl[n].in = in;
        tbl[n].st = st;
        tbl[n].o  = o;
        tbl[n].oc = oc;
        n++;
    endtask

    // Empty slot at addr 0 for origin and addr 1 for destination.
    task automatic full_ins(input int oc);
        add(I_BORDA | I_GNT, 0, O_ERD, oc);
        add(I_GNT, 1, O_REQ | O_ZERA, oc);
        add(I_GNT, 2, O_REQ | O_SEL1 | O_SEL3, oc);
        add(I_GNT, 3, O_INSO, oc);
        add(I_GNT, 4, O_REQ, oc + 1);
        add(I_GNT, 5, O_INSD, oc + 1);
        add(I_GNT, 6, O_PRONTO, oc + 2);
        add(8'h00, 0, 13'h0, oc + 2);
    endtask

    // Origin already queued at addr 0, destination written at addr 1.
    task automatic half_ins(input int oc);
        add(I_BORDA | I_GNT, 0, O_ERD, oc);
        add(I_GNT, 1, O_REQ | O_ZERA, oc);
        add(I_GNT | I_RSZ | I_RO, 2, O_REQ | O_SEL1 | O_SEL3 | O_ERC | O_CONTA, oc);
        add(I_GNT, 4, O_REQ, oc);
        add(I_GNT, 5, O_INSD, oc);
        add(I_GNT, 6, O_PRONTO, oc + 1);
        add(8'h00, 0, 13'h0, oc + 1);
    endtask

    task automatic drive(input logic [7:0] in);
        {bordaNovoDestino, gnt_fila, shift_fila, ramSecDifZero, carona_origem,
         carona_destino, andarRepetidoOrigem, andarRepetidoDestino} = in;
    endtask

    task automatic chk(input string nm, input logic [12:0] o, input int st, input int oc);
        total++;
        if (dut_o !== o || db_estado !== 4'(st) || ocupacao !== 5'(oc)) begin
            bad++;
            $display("FAIL %s: got o=%h st=%0d oc=%0d, want o=%h st=%0d oc=%0d",
                     nm, dut_o, db_estado, ocupacao, o, st, oc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // empty queue: minimum latency, pronto 6 cycles after request
        full_ins(0);
        // repeated origin at addr 0, repeated destination at addr 2: no writes
        add(I_BORDA | I_GNT, 0, O_ERD, 2);
        add(I_GNT, 1, O_REQ | O_ZERA, 2);
        add(I_GNT | I_RSZ | I_RO, 2, O_REQ | O_SEL1 | O_SEL3 | O_ERC | O_CONTA, 2);
        add(I_GNT | I_RSZ, 4, O_REQ | O_CONTA, 2);
        add(I_GNT | I_RSZ | I_RD, 4, O_REQ, 2);
        add(I_GNT, 6, O_PRONTO, 2);
        add(8'h00, 0, 13'h0, 2);
        half_ins(2);
        // 3 entries: origin rides along at addr 1, destination at addr 3
        add(I_BORDA | I_GNT, 0, O_ERD, 3);
        add(I_GNT, 1, O_REQ | O_ZERA, 3);
        add(I_GNT | I_RSZ, 2, O_REQ | O_SEL1 | O_SEL3 | O_CONTA, 3);
        add(I_GNT | I_RSZ | I_CO, 2, O_REQ | O_SEL1, 3);
        add(I_GNT | I_RSZ, 3, O_INSO, 3);
        add(I_GNT | I_RSZ, 4, O_REQ | O_CONTA, 4);
        add(I_GNT | I_RSZ | I_CD, 4, O_REQ, 4);
        add(I_GNT, 5, O_INSD, 4);
        add(I_GNT, 6, O_PRONTO, 5);
        add(8'h00, 0, 13'h0, 5);
        add(I_SHIFT, 0, 13'h0, 5);
        add(I_SHIFT, 0, 13'h0, 4);
        // busy request mid-scan, pop coincident with destination write
        add(I_BORDA | I_GNT, 0, O_ERD, 3);
        add(I_GNT, 1, O_REQ | O_ZERA, 3);
        add(I_GNT, 2, O_REQ | O_SEL1 | O_SEL3, 3);
        add(I_GNT, 3, O_INSO, 3);
        add(I_GNT | I_BORDA, 4, O_REQ | O_DESC, 4);
        add(I_GNT | I_SHIFT, 5, O_INSD, 4);
        add(I_GNT, 6, O_PRONTO, 4);
        add(8'h00, 0, 13'h0, 4);
        // fill to 14, then the last admissible request brings it to 15
        for (int k = 0; k < 5; k++) full_ins(4 + 2 * k);
        half_ins(14);
        // 15 entries: rejected without any write
        add(I_BORDA | I_GNT, 0, O_ERD, 15);
        add(I_GNT, 1, O_REQ, 15);
        add(I_GNT, 7, O_ERRO, 15);
        add(8'h00, 0, 13'h0, 15);
        // grant never arrives: error 9 cycles after request, busy request dropped
        add(I_BORDA, 0, O_ERD, 15);
        add(8'h00, 1, O_REQ, 15);
        add(I_BORDA, 1, O_REQ | O_DESC, 15);
        for (int c = 0; c < 6; c++) add(8'h00, 1, O_REQ, 15);
        add(8'h00, 7, O_ERRO, 15);
        add(8'h00, 0, 13'h0, 15);
        // drain through pops, saturating at 0
        for (int v = 15; v >= 0; v--) add(I_SHIFT, 0, 13'h0, v);
        add(I_SHIFT, 0, 13'h0, 0);
        // every entry occupied and no match: scan ends at the last address
        add(I_BORDA | I_GNT, 0, O_ERD, 0);
        add(I_GNT, 1, O_REQ | O_ZERA, 0);
        for (int a = 0; a < PF - 1; a++)
            add(I_GNT | I_RSZ, 2, O_REQ | O_SEL1 | O_CONTA | ((a == 0) ? O_SEL3 : 13'h0), 0);
        add(I_GNT | I_RSZ, 2, O_REQ | O_SEL1, 0);
        add(I_GNT, 7, O_ERRO, 0);
        add(8'h00, 0, 13'h0, 0);

        reset = 1'b1;
        drive(8'h00);
        repeat (2) @(negedge clock);
        #1 chk("reset_state", 13'h0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            drive(tbl[i].in);
            #1 chk($sformatf("vec%0d", i), tbl[i].o, tbl[i].st, tbl[i].oc);
        end

        // reset during origin scan: strobes masked that cycle, idle afterwards
        @(negedge clock); drive(I_BORDA | I_GNT);
        #1 chk("rst_req", O_ERD, 0, 0);
        @(negedge clock); drive(I_GNT);
        #1 chk("rst_sol", O_REQ | O_ZERA, 1, 0);
        @(negedge clock); drive(I_GNT | I_RSZ); reset = 1'b1;
        #1 chk("rst_cycle", 13'h0, 2, 0);
        @(negedge clock); drive(8'h00); reset = 1'b0;
        #1 chk("rst_after", 13'h0, 0, 0);
        @(negedge clock); drive(I_BORDA | I_GNT);
        #1 chk("rst_newreq", O_ERD, 0, 0);
        @(negedge clock); drive(I_GNT);
        #1 chk("rst_newsol", O_REQ | O_ZERA, 1, 0);
        @(negedge clock); drive(8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smart_cargo_uc_insercao.md
Name: smart_cargo_uc_insercao

Overview:
- Control unit that inserts one transport request (origin, destination, type) into the elevator queue RAM.
- On each received serial request it arbitrates for the queue against the movement controller.
- It then scans the queue through the secondary address counter to find carona (ride-along) slots for origin and destination, and issues fit/write strobes.
- It tracks queue occupancy and rejects requests that cannot fit.

Parameters:
PROF_FILA, 16, queue depth in entries (secondary address range 0..PROF_FILA-1)
ADDR_W, 4, width of secondary address/occupancy counters
TIMEOUT_GNT, 1000, max cycles waiting for gnt_fila before aborting

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
bordaNovoDestino  in  1  one-cycle pulse: new serial request captured
gnt_fila  in  1  level: movement controller grants queue access
shift_fila  in  1  pulse: movement controller popped queue head
ramSecDifZero  in  1  entry at secondary address is non-empty
carona_origem  in  1  origin fits between previous and current entry
carona_destino  in  1  destination fits here and lies after origin slot
andarRepetidoOrigem  in  1  origin floor already queued, same direction
andarRepetidoDestino  in  1  destination floor already queued after origin slot
req_fila  out  1  request queue access
enableRegDestino  out  1  load destination register
select1  out  1  1 = compare origin, 0 = compare destination
select3  out  1  1 = previous-floor operand is current floor (address 0)
zeraAddrSecundario  out  1  clear secondary address counter
contaAddrSecundario  out  1  increment secondary address counter
enableRegCaronaOrigem  out  1  store origin slot address
fit  out  1  open slot at secondary address
enableRAM  out  1  write queue entry
guarda_origem_ram  out  1  1 = write origin, 0 = write destination
pronto  out  1  one-cycle pulse: request inserted
erro_fila_cheia  out  1  one-cycle pulse: request rejected
pedido_descartado  out  1  one-cycle pulse: request arrived while busy
ocupacao  out  ADDR_W+1  current number of queue entries
db_estado  out  4  state code for debug

Behaviour:
- Reset: state OCIOSO, all outputs 0, ocupacao 0, internal addr_q 0, timeout counter 0.
- addr_q shadows the datapath secondary counter: cleared with zeraAddrSecundario, incremented with contaAddrSecundario.
- select3 = (addr_q==0) in both BUSCA states, else 0.
- OCIOSO (0):
  - On bordaNovoDestino: enableRegDestino=1, go to SOLICITA.
- SOLICITA (1):
  - req_fila=1; timeout counter counts.
  - On gnt_fila=1 with ocupacao<=PROF_FILA-2: zeraAddrSecundario=1, go to BUSCA_ORIGEM.
  - On gnt_fila=1 with ocupacao>PROF_FILA-2: go to ERRO.
  - Counter reaching TIMEOUT_GNT-1: go to ERRO.
- BUSCA_ORIGEM (2): req_fila=1, select1=1. Priority order:
  - andarRepetidoOrigem: enableRegCaronaOrigem=1, contaAddrSecundario=1, go to BUSCA_DESTINO.
  - carona_origem or !ramSecDifZero: go to INSERE_ORIGEM.
  - addr_q==PROF_FILA-1: go to ERRO.
  - else contaAddrSecundario=1, stay.
- INSERE_ORIGEM (3):
  - fit=1, enableRAM=1, guarda_origem_ram=1, enableRegCaronaOrigem=1, contaAddrSecundario=1.
  - ocupacao+1; go to BUSCA_DESTINO.
- BUSCA_DESTINO (4): req_fila=1, select1=0. Priority order:
  - andarRepetidoDestino: go to FIM.
  - carona_destino or !ramSecDifZero: go to INSERE_DESTINO.
  - addr_q==PROF_FILA-1: go to ERRO.
  - else contaAddrSecundario=1.
- INSERE_DESTINO (5): fit=1, enableRAM=1, guarda_origem_ram=0, ocupacao+1, go to FIM.
- FIM (6): pronto=1, req_fila=0, go to OCIOSO.
- ERRO (7): erro_fila_cheia=1, req_fila=0, go to OCIOSO.
  - An origin already written is not rolled back; the admission check in SOLICITA makes this unreachable in legal use.
- req_fila drops to 0 in the cycle after the last RAM strobe.
- Busy requests: bordaNovoDestino in any state except OCIOSO produces pedido_descartado=1 the same cycle. State and registers are unaffected.
- ocupacao:
  - +1 per enableRAM; -1 per shift_fila, saturating at 0.
  - Simultaneous insert and shift: unchanged.
  - Never exceeds PROF_FILA.
- gnt_fila falling during the BUSCA/INSERE states is a protocol violation; the FSM continues regardless.
- Reset mid-operation: returns to OCIOSO next edge; no strobes asserted in that cycle.
- Minimum latency with an empty queue and gnt already high: pronto 6 cycles after the bordaNovoDestino edge.

Test Plan:
- Empty queue, gnt_fila=1, pulse request → sequence OCIOSO,SOLICITA,BUSCA_ORIGEM,INSERE_ORIGEM,BUSCA_DESTINO,INSERE_DESTINO,FIM; pronto at cycle 6; ocupacao=2; exactly 2 enableRAM pulses (guarda_origem_ram 1 then 0).
- Queue with 3 entries, carona_origem asserted at addr_q=1 → fit+enableRAM at addr 1; carona_destino at addr_q=3 → second insert; ocupacao 3→5.
- andarRepetidoOrigem at addr 0 and andarRepetidoDestino at addr 2 → no enableRAM; pronto pulse; ocupacao unchanged.
- ocupacao=15 (PROF_FILA=16), request → ERRO; erro_fila_cheia pulse; no fit/enableRAM.
- gnt_fila held 0, TIMEOUT_GNT=8 → erro_fila_cheia 9 cycles after request; second bordaNovoDestino during SOLICITA → pedido_descartado pulse.
- shift_fila coincident with INSERE_DESTINO at ocupacao=4 → ocupacao stays 4; reset asserted in BUSCA_ORIGEM → all outputs 0, db_estado=0 next cycle.
